ft245_fifo_responder: RTL and testbench
=======================================

// Module: ft245_fifo_responder
// PURPOSE
//  FT245-style USB FIFO device (responder end of RD/WR/RXF/TXE byte interface) in fabric, CLK-synchronous.
//  Lets the waveform-memory controller run against an on-chip PC side (bench bridge, UART bridge, self-test).
//  RX FIFO: host stream -> controller, popped by RD strobes. TX FIFO: controller -> host stream, pushed by WR strobes.
// PARAMETERS
//  RX_AW    4  log2 RX FIFO depth (16 bytes)
//  TX_AW    4  log2 TX FIFO depth (16 bytes)
//  RXF_HOLD 3  cycles RXF stays high after RD returns high (min RXF inactive time)
//  TXE_HOLD 3  cycles TXE stays high after WR falling edge (min TXE inactive time)
// PORTS
//  CLK         in   1       system clock, 125 MHz
//  RSTN        in   1       asynchronous reset, active low
//  RD          in   1       controller read strobe, active low
//  WR          in   1       controller write strobe; byte latched on falling edge
//  USB_DIN     in   8       USBX as driven by controller (valid while WR high)
//  USB_DOUT    out  8       byte driven onto USBX during a read
//  USB_OE      out  1       USBX output enable for USB_DOUT
//  RXF         out  1       low = RX byte available
//  TXE         out  1       low = TX space available
//  H_RX_DATA   in   8       host byte to controller
//  H_RX_VALID  in   1       host byte valid
//  H_RX_READY  out  1       RX FIFO not full
//  H_TX_DATA   out  8       controller byte to host (TX FIFO head)
//  H_TX_VALID  out  1       TX FIFO not empty
//  H_TX_READY  in   1       host accepts head
//  RX_LEVEL    out  RX_AW+1 RX occupancy
//  TX_LEVEL    out  TX_AW+1 TX occupancy
// BEHAVIOUR
//  Reset (RSTN=0): FIFOs empty, levels 0, RXF=1, TXE=1, USB_OE=0, USB_DOUT=0, H_RX_READY=0, H_TX_VALID=0,
//   FSMs idle, RD_q=1, WR_q=0. First CLK edge after release: TXE=0, H_RX_READY=1.
//  RD_q/WR_q: registered copies of RD/WR. Fall = previous 1, current 0.
//  Host sides: push when H_RX_VALID&H_RX_READY; pop when H_TX_VALID&H_TX_READY. Ready/valid are registered full/empty.
//   Push and pop in the same cycle update level by net 0. Both are legal at any occupancy meeting the flags.
//  RX FSM RX_IDLE -> RX_READ -> RX_HOLD -> RX_IDLE:
//   RX_IDLE: RXF = (RX empty). On RD fall with RXF=0, pop head into USB_DOUT, set USB_OE=1 and RXF=1, go to RX_READ.
//    All three take effect on the next edge (1-cycle latency).
//   RX_READ: hold USB_DOUT and USB_OE while RD=0. RD seen high: drop USB_OE on that edge, load hold counter, go to RX_HOLD.
//   RX_HOLD: RXF=1 for RXF_HOLD cycles, then RX_IDLE. Pushes continue throughout the read cycle.
//   RD fall with RXF=1 is a violation: no pop; USB_DOUT keeps the last byte; OE follows RD normally.
//  TX FSM TX_IDLE -> TX_ARMED -> TX_HOLD -> TX_IDLE:
//   While WR=1, latch USB_DIN every cycle. This register holds the last value seen before WR fell.
//   TX_IDLE: TXE = (TX full). WR rise: go to TX_ARMED.
//   TX_ARMED: on WR fall, push the latched byte if not full, set TXE=1, and go to TX_HOLD.
//   TX_HOLD: TXE=1 for TXE_HOLD cycles, then TX_IDLE, where TXE re-evaluates full.
//   WR fall with TX full or TXE=1 is a violation: byte dropped, FIFO unchanged.
//  RX and TX paths are fully independent. Simultaneous RD fall and WR fall are both serviced.
//  Pointers are binary and wrap modulo 2^AW. Level = wr_ptr - rd_ptr on AW+1 bits. Full is level == 2^AW.
//  Reset mid-transfer: everything returns to reset values immediately (asynchronous); the partial byte is lost.
// CONFIGURATION
//  FT245_PROTO_CHECK_EN defined: adds output ERR[2:0], sticky until reset:
//   [0] RD fall while RXF=1 (underrun)
//   [1] WR fall while TXE=1 (overrun/drop)
//   [2] RD=0 and WR=1 in the same cycle (bus conflict)
//  FT245_PROTO_CHECK_EN undefined: ERR port and logic are absent; violations are silently handled as above.
// STRUCTURE
//  Package ft245_pkg:
//   rx_state_t {RX_IDLE, RX_READ, RX_HOLD} and tx_state_t {TX_IDLE, TX_ARMED, TX_HOLD}
//   default RX_AW/TX_AW/RXF_HOLD/TXE_HOLD constants
//   ERR bit index constants
//  Sub-module sync_fifo (params DW, AW; push/pop/full/empty/level/head, show-ahead) is instantiated twice (RX, TX).
//  Top holds the two FSMs, hold counters, edge detectors, WR data latch and checker.
// TESTING
//  1 Reset release -> RXF=1, TXE=0 on 1st edge; push 8'h07 -> RXF=0 next edge. RD low 6 cycles -> USB_OE=1,
//    USB_DOUT=8'h07 from 1 cycle after fall; RXF high for RD-low time + 3 cycles.
//  2 Push 16 bytes 0x00..0x0F -> H_RX_READY=0, RX_LEVEL=16. 17th byte is not accepted.
//    16 RD strobes return 0x00..0x0F in order, then RXF stays 1.
//  3 Controller pattern (WR high 5 cycles with USB_DIN=8'hA5, low 7; WR high with 8'h3C) with H_TX_READY=1 ->
//    H_TX_DATA sequence A5,3C; TXE high 3 cycles after each fall.
//  4 H_TX_READY=0, 16 writes -> TXE stays 1 at TX_LEVEL=16. 17th write dropped (ERR[1]=1 with check).
//    One host pop -> TXE=0 after hold.
//  5 RD strobe with RX empty -> no level change, USB_DOUT unchanged, ERR[0]=1. RD and WR overlapping -> ERR[2]=1,
//    both serviced.
//  6 RSTN low mid-read (RD=0, USB_OE=1) and mid-write -> USB_OE=0, RXF=1, TXE=1, levels 0 immediately.
//    Normal operation resumes after release.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared types and defaults for the FT245-style FIFO responder.
// Optional protocol checker is enabled with FT245_PROTO_CHECK_EN.
package ft245_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_READ = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_ARMED = 2'd1,
    TX_HOLD  = 2'd2
  } tx_state_t;

  localparam int FT245_RX_AW    = 4;
  localparam int FT245_TX_AW    = 4;
  localparam int FT245_RXF_HOLD = 3;
  localparam int FT245_TXE_HOLD = 3;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_CONFLICT = 2;

endpackage

// File: rtl/ft245_fifo_responder_sync_fifo.sv
// Show-ahead synchronous FIFO with binary AW+1 bit pointers and a registered level.
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic [AW:0]   level_nxt
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ZERO  = {(AW+1){1'b0}};

  logic [DW-1:0] mem_r [2**AW];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   level_r;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic [AW:0]   wr_ptr_nxt_s;
  logic [AW:0]   rd_ptr_nxt_s;

  assign full         = (level_r == DEPTH);
  assign empty        = (level_r == ZERO);
  assign push_ok_s    = push & ~full;
  assign pop_ok_s     = pop & ~empty;
  assign wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
  assign rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
  assign level_nxt    = wr_ptr_nxt_s - rd_ptr_nxt_s;
  assign level        = level_r;
  assign head         = mem_r[rd_ptr_r[AW-1:0]];

  // storage write port
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // pointer and level registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_r <= ZERO;
      rd_ptr_r <= ZERO;
      level_r  <= ZERO;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt;
    end
  end

endmodule

// File: rtl/ft245_fifo_responder.sv
// FT245-style FIFO device responder: RX/TX byte FIFOs behind RD/WR/RXF/TXE strobes.
// Define FT245_PROTO_CHECK_EN to add the sticky ERR[2:0] protocol checker output.
module ft245_fifo_responder
  import ft245_pkg::*;
#(
  parameter int RX_AW    = FT245_RX_AW,
  parameter int TX_AW    = FT245_TX_AW,
  parameter int RXF_HOLD = FT245_RXF_HOLD,
  parameter int TXE_HOLD = FT245_TXE_HOLD
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         RD,
  input  logic         WR,
  input  logic [7:0]   USB_DIN,
  output logic [7:0]   USB_DOUT,
  output logic         USB_OE,
  output logic         RXF,
  output logic         TXE,
  input  logic [7:0]   H_RX_DATA,
  input  logic         H_RX_VALID,
  output logic         H_RX_READY,
  output logic [7:0]   H_TX_DATA,
  output logic         H_TX_VALID,
  input  logic         H_TX_READY,
  output logic [RX_AW:0] RX_LEVEL,
  output logic [TX_AW:0] TX_LEVEL
`ifdef FT245_PROTO_CHECK_EN
  ,
  output logic [2:0]   ERR
`endif
);

  localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_ZERO  = {(RX_AW+1){1'b0}};
  localparam logic [TX_AW:0] TX_ZERO  = {(TX_AW+1){1'b0}};
  localparam logic [7:0]     RX_LOAD  = 8'(RXF_HOLD - 1);
  localparam logic [7:0]     TX_LOAD  = 8'(TXE_HOLD - 1);

  logic rd_q_r, wr_q_r;
  logic rd_fall_s, wr_fall_s, wr_rise_s;

  rx_state_t rx_state_r, rx_state_nxt_s;
  tx_state_t tx_state_r, tx_state_nxt_s;
  logic [7:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [7:0] tx_cnt_r, tx_cnt_nxt_s;

  logic       rxf_r, txe_r, oe_r, rx_ready_r, tx_valid_r;
  logic [7:0] dout_r, din_r;

  logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]       rx_head_s;
  logic [RX_AW:0]   rx_level_s, rx_level_nxt_s;
  logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [TX_AW:0]   tx_level_s, tx_level_nxt_s;

  assign rd_fall_s = rd_q_r & ~RD;
  assign wr_fall_s = wr_q_r & ~WR;
  assign wr_rise_s = ~wr_q_r & WR;

  assign rx_push_s = H_RX_VALID & rx_ready_r & ~rx_full_s;
  assign rx_pop_s  = (rx_state_r == RX_IDLE) & rd_fall_s & ~rxf_r & ~rx_empty_s;
  // A fall seen in IDLE covers a rise that arrived while TXE was still held high.
  assign tx_push_s = ((tx_state_r == TX_IDLE) | (tx_state_r == TX_ARMED)) &
                     wr_fall_s & ~txe_r & ~tx_full_s;
  assign tx_pop_s  = tx_valid_r & H_TX_READY & ~tx_empty_s;

  sync_fifo #(.DW(8), .AW(RX_AW)) u_rx_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (rx_push_s),
    .push_data (H_RX_DATA),
    .pop       (rx_pop_s),
    .head      (rx_head_s),
    .full      (rx_full_s),
    .empty     (rx_empty_s),
    .level     (rx_level_s),
    .level_nxt (rx_level_nxt_s)
  );

  sync_fifo #(.DW(8), .AW(TX_AW)) u_tx_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .push      (tx_push_s),
    .push_data (din_r),
    .pop       (tx_pop_s),
    .head      (H_TX_DATA),
    .full      (tx_full_s),
    .empty     (tx_empty_s),
    .level     (tx_level_s),
    .level_nxt (tx_level_nxt_s)
  );

  // RX strobe FSM next-state
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_pop_s) rx_state_nxt_s = RX_READ;
        else          rx_state_nxt_s = RX_IDLE;
      end
      RX_READ: begin
        if (RD) begin
          rx_state_nxt_s = RX_HOLD;
          rx_cnt_nxt_s   = RX_LOAD;
        end else begin
          rx_state_nxt_s = RX_READ;
        end
      end
      RX_HOLD: begin
        if (rx_cnt_r == 8'd0) rx_state_nxt_s = RX_IDLE;
        else                  rx_cnt_nxt_s   = rx_cnt_r - 8'd1;
      end
      default: rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // TX strobe FSM next-state
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    case (tx_state_r)
      TX_IDLE, TX_ARMED: begin
        if (wr_fall_s) begin
          tx_state_nxt_s = TX_HOLD;
          tx_cnt_nxt_s   = TX_LOAD;
        end else if (wr_rise_s) begin
          tx_state_nxt_s = TX_ARMED;
        end else begin
          tx_state_nxt_s = tx_state_r;
        end
      end
      TX_HOLD: begin
        if (tx_cnt_r == 8'd0) tx_state_nxt_s = TX_IDLE;
        else                  tx_cnt_nxt_s   = tx_cnt_r - 8'd1;
      end
      default: tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // Flags are registered from next-state so they match the FIFOs one edge later.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_q_r     <= 1'b1;
      wr_q_r     <= 1'b0;
      rx_state_r <= RX_IDLE;
      tx_state_r <= TX_IDLE;
      rx_cnt_r   <= 8'd0;
      tx_cnt_r   <= 8'd0;
      rxf_r      <= 1'b1;
      txe_r      <= 1'b1;
      oe_r       <= 1'b0;
      dout_r     <= 8'd0;
      din_r      <= 8'd0;
      rx_ready_r <= 1'b0;
      tx_valid_r <= 1'b0;
    end else begin
      rd_q_r     <= RD;
      wr_q_r     <= WR;
      rx_state_r <= rx_state_nxt_s;
      tx_state_r <= tx_state_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      rxf_r      <= (rx_state_nxt_s == RX_IDLE) ? (rx_level_nxt_s == RX_ZERO) : 1'b1;
      txe_r      <= (tx_state_nxt_s == TX_HOLD) ? 1'b1 : (tx_level_nxt_s == TX_DEPTH);
      oe_r       <= ~RD;
      dout_r     <= rx_pop_s ? rx_head_s : dout_r;
      din_r      <= WR ? USB_DIN : din_r;
      rx_ready_r <= (rx_level_nxt_s != RX_DEPTH);
      tx_valid_r <= (tx_level_nxt_s != TX_ZERO);
    end
  end

`ifdef FT245_PROTO_CHECK_EN
  logic [2:0] err_r;

  // sticky protocol violation flags
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_r <= 3'b000;
    end else begin
      err_r[ERR_UNDERRUN] <= err_r[ERR_UNDERRUN] | (rd_fall_s & rxf_r);
      err_r[ERR_OVERRUN]  <= err_r[ERR_OVERRUN]  | (wr_fall_s & (txe_r | tx_full_s));
      err_r[ERR_CONFLICT] <= err_r[ERR_CONFLICT] | (~RD & WR);
    end
  end

  assign ERR = err_r;
`endif

  assign USB_DOUT   = dout_r;
  assign USB_OE     = oe_r;
  assign RXF        = rxf_r;
  assign TXE        = txe_r;
  assign H_RX_READY = rx_ready_r;
  assign H_TX_VALID = tx_valid_r;
  assign RX_LEVEL   = rx_level_s;
  assign TX_LEVEL   = tx_level_s;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Directed self-checking bench for ft245_fifo_responder (ERR checks only with FT245_PROTO_CHECK_EN).
module tb_ft245_fifo_responder;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       RD, WR;
  logic [7:0] USB_DIN, USB_DOUT;
  logic       USB_OE, RXF, TXE;
  logic [7:0] H_RX_DATA, H_TX_DATA;
  logic       H_RX_VALID, H_RX_READY, H_TX_VALID, H_TX_READY;
  logic [4:0] RX_LEVEL, TX_LEVEL;
`ifdef FT245_PROTO_CHECK_EN
  logic [2:0] ERR;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] got;

  ft245_fifo_responder dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .RD         (RD),
    .WR         (WR),
    .USB_DIN    (USB_DIN),
    .USB_DOUT   (USB_DOUT),
    .USB_OE     (USB_OE),
    .RXF        (RXF),
    .TXE        (TXE),
    .H_RX_DATA  (H_RX_DATA),
    .H_RX_VALID (H_RX_VALID),
    .H_RX_READY (H_RX_READY),
    .H_TX_DATA  (H_TX_DATA),
    .H_TX_VALID (H_TX_VALID),
    .H_TX_READY (H_TX_READY),
    .RX_LEVEL   (RX_LEVEL),
    .TX_LEVEL   (TX_LEVEL)
`ifdef FT245_PROTO_CHECK_EN
    ,
    .ERR        (ERR)
`endif
  );

  always #4 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_push(input logic [7:0] d);
    H_RX_VALID = 1'b1;
    H_RX_DATA  = d;
    tick();
    H_RX_VALID = 1'b0;
  endtask

  task automatic rd_strobe(output logic [7:0] b);
    RD = 1'b0;
    tick();
    b  = USB_DOUT;
    RD = 1'b1;
    tick();
    repeat (3) tick();
  endtask

  task automatic wr_byte(input logic [7:0] d);
    WR = 1'b1;
    USB_DIN = d;
    tick();
    tick();
    WR = 1'b0;
    USB_DIN = 8'h00;
    tick();
    repeat (3) tick();
  endtask

  initial begin
    RSTN = 1'b0; RD = 1'b1; WR = 1'b0; USB_DIN = 8'h00;
    H_RX_DATA = 8'h00; H_RX_VALID = 1'b0; H_TX_READY = 1'b0;
    repeat (3) tick();
    chk("rst_rxf", RXF, 1);
    chk("rst_txe", TXE, 1);
    chk("rst_oe", USB_OE, 0);
    chk("rst_dout", USB_DOUT, 0);
    chk("rst_rx_ready", H_RX_READY, 0);
    chk("rst_tx_valid", H_TX_VALID, 0);
    chk("rst_levels", {RX_LEVEL, TX_LEVEL}, 0);
    RSTN = 1'b1;
    tick();
    chk("rel_txe", TXE, 0);
    chk("rel_rx_ready", H_RX_READY, 1);
    chk("rel_rxf", RXF, 1);

    // 1: single byte read with RXF hold timing, push during read
    rx_push(8'h07);
    chk("t1_rxf_low", RXF, 0);
    chk("t1_level", RX_LEVEL, 1);
    RD = 1'b0; H_RX_VALID = 1'b1; H_RX_DATA = 8'h08;
    tick();
    H_RX_VALID = 1'b0;
    chk("t1_oe", USB_OE, 1);
    chk("t1_dout", USB_DOUT, 8'h07);
    chk("t1_rxf_read", RXF, 1);
    chk("t1_level_rw", RX_LEVEL, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_oe", USB_OE, 1);
      chk("t1_hold_dout", USB_DOUT, 8'h07);
      chk("t1_hold_rxf", RXF, 1);
    end
    RD = 1'b1;
    tick();
    chk("t1_oe_drop", USB_OE, 0);
    chk("t1_rxf_h0", RXF, 1);
    tick();
    chk("t1_rxf_h1", RXF, 1);
    tick();
    chk("t1_rxf_h2", RXF, 1);
    tick();
    chk("t1_rxf_ret", RXF, 0);
    rd_strobe(got);
    chk("t1_second", got, 8'h08);
    chk("t1_empty_rxf", RXF, 1);

    // 2: fill RX, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) rx_push(8'(i));
    chk("t2_ready_full", H_RX_READY, 0);
    chk("t2_level16", RX_LEVEL, 16);
    rx_push(8'hEE);
    chk("t2_level17", RX_LEVEL, 16);
    for (int i = 0; i < 16; i++) begin
      rd_strobe(got);
      chk("t2_order", got, i);
    end
    chk("t2_rxf_end", RXF, 1);
    chk("t2_level_end", RX_LEVEL, 0);

    // 3: controller write pattern to host
    H_TX_READY = 1'b1;
    WR = 1'b1; USB_DIN = 8'hA5;
    repeat (5) tick();
    WR = 1'b0; USB_DIN = 8'hFF;
    tick();
    chk("t3_valid_a", H_TX_VALID, 1);
    chk("t3_data_a", H_TX_DATA, 8'hA5);
    chk("t3_txe_h0", TXE, 1);
    tick();
    chk("t3_txe_h1", TXE, 1);
    chk("t3_popped", TX_LEVEL, 0);
    tick();
    chk("t3_txe_h2", TXE, 1);
    tick();
    chk("t3_txe_ret", TXE, 0);
    repeat (3) tick();
    WR = 1'b1; USB_DIN = 8'h3C;
    repeat (5) tick();
    WR = 1'b0; USB_DIN = 8'hFF;
    tick();
    chk("t3_data_b", H_TX_DATA, 8'h3C);
    chk("t3_valid_b", H_TX_VALID, 1);
    repeat (4) tick();
    H_TX_READY = 1'b0;
    chk("t3_level_end", TX_LEVEL, 0);

    // 4: fill TX with host stalled, drop 17th, one pop frees TXE
    for (int i = 0; i < 16; i++) wr_byte(8'(8'h40 + i));
    chk("t4_level16", TX_LEVEL, 16);
    chk("t4_txe_full", TXE, 1);
    chk("t4_head", H_TX_DATA, 8'h40);
    wr_byte(8'h99);
    chk("t4_drop", TX_LEVEL, 16);
`ifdef FT245_PROTO_CHECK_EN
    chk("t4_err1", ERR[1], 1);
`endif
    H_TX_READY = 1'b1;
    tick();
    H_TX_READY = 1'b0;
    chk("t4_level15", TX_LEVEL, 15);
    chk("t4_txe_free", TXE, 0);
    for (int i = 1; i < 16; i++) begin
      chk("t4_drain", H_TX_DATA, 8'h40 + i);
      H_TX_READY = 1'b1;
      tick();
    end
    H_TX_READY = 1'b0;
    chk("t4_level0", TX_LEVEL, 0);

    // 5: underrun read, then overlapping RD and WR
    RD = 1'b0;
    tick();
    chk("t5_oe_follow", USB_OE, 1);
    chk("t5_dout_keep", USB_DOUT, 8'h0F);
    chk("t5_level", RX_LEVEL, 0);
    RD = 1'b1;
    tick();
    rx_push(8'h55);
    WR = 1'b1; USB_DIN = 8'h66;
    tick();
    RD = 1'b0;
    tick();
    chk("t5_rd_dout", USB_DOUT, 8'h55);
    WR = 1'b0;
    tick();
    chk("t5_wr_level", TX_LEVEL, 1);
    chk("t5_wr_data", H_TX_DATA, 8'h66);
    chk("t5_rx_level", RX_LEVEL, 0);
    RD = 1'b1;
    repeat (4) tick();
`ifdef FT245_PROTO_CHECK_EN
    chk("t5_err", ERR, 3'b111);
`endif
    H_TX_READY = 1'b1;
    tick();
    H_TX_READY = 1'b0;
    chk("t5_tx_drained", TX_LEVEL, 0);

    // 6: asynchronous reset mid-read and mid-write
    rx_push(8'h11);
    rx_push(8'h22);
    RD = 1'b0;
    tick();
    chk("t6_oe_pre", USB_OE, 1);
    WR = 1'b1; USB_DIN = 8'h77;
    tick();
    #2 RSTN = 1'b0;
    #1;
    chk("t6_oe", USB_OE, 0);
    chk("t6_rxf", RXF, 1);
    chk("t6_txe", TXE, 1);
    chk("t6_levels", {RX_LEVEL, TX_LEVEL}, 0);
    RD = 1'b1; WR = 1'b0;
    tick();
    RSTN = 1'b1;
    tick();
    chk("t6_rel_txe", TXE, 0);
    chk("t6_rel_ready", H_RX_READY, 1);
`ifdef FT245_PROTO_CHECK_EN
    chk("t6_err_clr", ERR, 3'b000);
`endif
    rx_push(8'h33);
    rd_strobe(got);
    chk("t6_rx_resume", got, 8'h33);
    wr_byte(8'h44);
    chk("t6_tx_level", TX_LEVEL, 1);
    chk("t6_tx_data", H_TX_DATA, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
